// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command arbiter.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arb_state_t;

  localparam logic [1:0] REQ_INIT  = 2'd0;
  localparam logic [1:0] REQ_TEXT  = 2'd1;
  localparam logic [1:0] REQ_CGRAM = 2'd2;

  localparam int unsigned DEFAULT_TIMEOUT = 32'd50000;

  // Init sequencer always wins; text/CGRAM ties go to whichever was not served last.
  function automatic logic [1:0] pick_winner(input logic [2:0] req, input logic last_cgram);
    logic [1:0] w;
    w = REQ_INIT;
    if (req[REQ_INIT]) begin
      w = REQ_INIT;
    end else if (req[REQ_TEXT] && req[REQ_CGRAM]) begin
      w = last_cgram ? REQ_TEXT : REQ_CGRAM;
    end else if (req[REQ_TEXT]) begin
      w = REQ_TEXT;
    end else if (req[REQ_CGRAM]) begin
      w = REQ_CGRAM;
    end else begin
      w = REQ_INIT;
    end
    return w;
  endfunction

endpackage

// File: rtl/lcd_watchdog.sv
// Saturating 16-bit cycle counter; expired flags the last allowed WAIT_DONE cycle.
module lcd_watchdog
  import lcd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 32'd1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 16'd0;
    end else if (enable && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Arbitrates three LCD command sources onto one transfer engine, one
// transaction at a time, with a watchdog abort and a one-cycle idle gap.
module lcd_cmd_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [2:0]      req,
  input  logic [2:0][7:0] cmd_in,
  input  logic [2:0]      rs_in,
  input  logic [2:0]      mode4bit_in,
  input  logic [2:0]      read_busy_in,
  output logic [2:0]      grant,
  output logic [2:0]      done,
  output logic [2:0]      timeout_err,
  output logic            sendCommand,
  output logic [7:0]      command,
  output logic            command_rs,
  output logic            mode4bit,
  output logic            read_busy,
  input  logic            commandDone
);

  arb_state_t state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic       send_q, send_d;
  logic [7:0] cmd_q, cmd_d;
  logic       rs_q, rs_d;
  logic       m4_q, m4_d;
  logic       rb_q, rb_d;
  logic       last_cgram_q, last_cgram_d;
  logic [1:0] win_s;
  logic       wd_clear_s;
  logic       wd_expired_s;
  logic       done_fire_s;
  logic       to_fire_s;

  assign win_s = pick_winner(req, last_cgram_q);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    send_d       = 1'b0;
    cmd_d        = cmd_q;
    rs_d         = rs_q;
    m4_d         = m4_q;
    rb_d         = rb_q;
    last_cgram_d = last_cgram_q;
    wd_clear_s   = 1'b0;
    done_fire_s  = 1'b0;
    to_fire_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = ISSUE;
          grant_d    = 3'b001 << win_s;
          send_d     = 1'b1;
          cmd_d      = cmd_in[win_s];
          rs_d       = rs_in[win_s];
          m4_d       = mode4bit_in[win_s];
          rb_d       = read_busy_in[win_s];
          wd_clear_s = 1'b1;
          if (win_s == REQ_TEXT) begin
            last_cgram_d = 1'b0;
          end else if (win_s == REQ_CGRAM) begin
            last_cgram_d = 1'b1;
          end else begin
            last_cgram_d = last_cgram_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      // commandDone is deliberately not looked at here.
      ISSUE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (commandDone) begin
          done_fire_s = 1'b1;
          state_d     = RELEASE;
          grant_d     = 3'b000;
        end else if (wd_expired_s) begin
          to_fire_s = 1'b1;
          state_d   = RELEASE;
          grant_d   = 3'b000;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      grant_q      <= 3'b000;
      send_q       <= 1'b0;
      cmd_q        <= 8'h00;
      rs_q         <= 1'b0;
      m4_q         <= 1'b0;
      rb_q         <= 1'b0;
      last_cgram_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      send_q       <= send_d;
      cmd_q        <= cmd_d;
      rs_q         <= rs_d;
      m4_q         <= m4_d;
      rb_q         <= rb_d;
      last_cgram_q <= last_cgram_d;
    end
  end

  lcd_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (CLK),
    .rst    (RESET),
    .clear  (wd_clear_s),
    .enable (state_q == WAIT_DONE),
    .expired(wd_expired_s)
  );

  // grant_q still identifies the owner during WAIT_DONE, so it steers the pulses.
  assign done        = grant_q & {3{done_fire_s}};
  assign timeout_err = grant_q & {3{to_fire_s}};
  assign grant       = grant_q;
  assign sendCommand = send_q;
  assign command     = cmd_q;
  assign command_rs  = rs_q;
  assign mode4bit    = m4_q;
  assign read_busy   = rb_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Scoreboard bench: drivers queue expected issue/completion events, a
// negedge monitor pops and compares them whenever the DUT pulses.
module tb_lcd_cmd_arbiter;

  logic            CLK = 1'b0;
  logic            RESET = 1'b0;
  logic [2:0]      req = 3'b000;
  logic [2:0][7:0] cmd_in = 24'h0;
  logic [2:0]      rs_in = 3'b000;
  logic [2:0]      mode4bit_in = 3'b000;
  logic [2:0]      read_busy_in = 3'b000;
  logic            commandDone = 1'b0;
  logic [2:0]      grant, done, timeout_err;
  logic            sendCommand, command_rs, mode4bit, read_busy;
  logic [7:0]      command;

  typedef struct {
    logic [2:0] g;
    logic [7:0] cmd;
    logic       rs, m4, rb;
  } issue_t;

  typedef struct {
    logic [2:0] d;
    logic [2:0] t;
    int         lat;
    logic [7:0] cmd;
  } comp_t;

  issue_t iq[$];
  comp_t  cq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_cyc = 0;

  lcd_cmd_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .cmd_in(cmd_in), .rs_in(rs_in),
    .mode4bit_in(mode4bit_in), .read_busy_in(read_busy_in), .grant(grant),
    .done(done), .timeout_err(timeout_err), .sendCommand(sendCommand),
    .command(command), .command_rs(command_rs), .mode4bit(mode4bit),
    .read_busy(read_busy), .commandDone(commandDone)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_issue(input logic [2:0] g, input logic [7:0] c, input logic rs,
                            input logic m4, input logic rb);
    issue_t e;
    e.g = g; e.cmd = c; e.rs = rs; e.m4 = m4; e.rb = rb;
    iq.push_back(e);
  endtask

  task automatic push_comp(input logic [2:0] d, input logic [2:0] t, input int lat,
                           input logic [7:0] c);
    comp_t e;
    e.d = d; e.t = t; e.lat = lat; e.cmd = c;
    cq.push_back(e);
  endtask

  // Monitor: every sendCommand / done / timeout_err pulse must match a queued expectation.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (sendCommand) begin
        if (iq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_send grant=%b command=%h", grant, command);
        end else begin
          issue_t e;
          e = iq.pop_front();
          chk("issue_grant", 32'(grant), 32'(e.g));
          chk("issue_command", 32'(command), 32'(e.cmd));
          chk("issue_quals", 32'({command_rs, mode4bit, read_busy}), 32'({e.rs, e.m4, e.rb}));
          issue_cyc = cyc;
        end
      end
      if ((|done) || (|timeout_err)) begin
        if (cq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_completion done=%b timeout_err=%b", done, timeout_err);
        end else begin
          comp_t e;
          e = cq.pop_front();
          chk("comp_done", 32'(done), 32'(e.d));
          chk("comp_timeout", 32'(timeout_err), 32'(e.t));
          chk("comp_latency", 32'(cyc - issue_cyc), 32'(e.lat));
          chk("comp_command", 32'(command), 32'(e.cmd));
        end
      end
    end
  end

  // Waits for the issue pulse; it must arrive one edge after req is presented in IDLE.
  task automatic wait_issue(input string name);
    int n;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!sendCommand && n < 20);
    chk(name, 32'(n), 32'd1);
  endtask

  // Called in the ISSUE cycle; finishes in an IDLE cycle.
  task automatic complete(input int dly, input bit early, input bit chg, input logic [7:0] cexp);
    if (early) commandDone = 1'b1;
    for (int i = 0; i < dly; i++) begin
      @(posedge CLK); #1;
      commandDone = 1'b0;
      if (chg) cmd_in = {8'hFF, 8'hFF, 8'hFF};
    end
    commandDone = 1'b1;
    @(posedge CLK); #1;
    commandDone = 1'b0;
    chk("release_grant", 32'(grant), 32'd0);
    chk("release_send", 32'(sendCommand), 32'd0);
    chk("release_command", 32'(command), 32'(cexp));
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [2:0] g;
    #1 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", 32'({grant, done, timeout_err, sendCommand, command, command_rs, mode4bit, read_busy}), 32'd0);
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk("idle_no_send", 32'({sendCommand, grant}), 32'd0);

    // Priority then round-robin: 0,0,0 while req[0] held, then 1,2,1,2.
    cmd_in = {8'h52, 8'h41, 8'h30};
    rs_in = 3'b010; mode4bit_in = 3'b001; read_busy_in = 3'b100;
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      push_issue(3'b001, 8'h30, 1'b0, 1'b1, 1'b0);
      push_comp(3'b001, 3'b000, 2, 8'h30);
      wait_issue("prio_latency");
      complete(2, 1'b0, 1'b0, 8'h30);
    end
    req = 3'b110;
    for (int i = 0; i < 4; i++) begin
      g = (i % 2 == 0) ? 3'b010 : 3'b100;
      if (g == 3'b010) begin
        push_issue(3'b010, 8'h41, 1'b1, 1'b0, 1'b0);
        push_comp(3'b010, 3'b000, 2, 8'h41);
      end else begin
        push_issue(3'b100, 8'h52, 1'b0, 1'b0, 1'b1);
        push_comp(3'b100, 3'b000, 2, 8'h52);
      end
      wait_issue("rr_latency");
      if (i == 3) req = 3'b000;
      complete(2, 1'b0, 1'b0, g == 3'b010 ? 8'h41 : 8'h52);
    end
    mode4bit_in = 3'b000; read_busy_in = 3'b000;

    // Text sender, done 5 cycles after issue; req dropped mid-transaction.
    push_issue(3'b010, 8'h41, 1'b1, 1'b0, 1'b0);
    push_comp(3'b010, 3'b000, 5, 8'h41);
    req = 3'b010;
    wait_issue("text_latency");
    req = 3'b000;
    complete(5, 1'b0, 1'b0, 8'h41);

    // Timeout: 8 WAIT_DONE cycles, no done.
    push_issue(3'b100, 8'h52, 1'b0, 1'b0, 1'b0);
    push_comp(3'b000, 3'b100, 8, 8'h52);
    req = 3'b100;
    wait_issue("timeout_latency");
    req = 3'b000;
    repeat (9) @(posedge CLK);
    #1;
    chk("timeout_release_grant", 32'(grant), 32'd0);
    @(posedge CLK); #1;

    // commandDone coinciding with the timeout cycle: done wins.
    push_issue(3'b010, 8'h41, 1'b1, 1'b0, 1'b0);
    push_comp(3'b010, 3'b000, 8, 8'h41);
    req = 3'b010;
    wait_issue("tie_latency");
    req = 3'b000;
    complete(8, 1'b0, 1'b0, 8'h41);

    // commandDone during ISSUE is ignored; only the later one completes.
    push_issue(3'b010, 8'h41, 1'b1, 1'b0, 1'b0);
    push_comp(3'b010, 3'b000, 3, 8'h41);
    req = 3'b010;
    wait_issue("early_latency");
    req = 3'b000;
    complete(3, 1'b1, 1'b0, 8'h41);

    // cmd_in changes during WAIT_DONE must not reach command.
    push_issue(3'b010, 8'h41, 1'b1, 1'b0, 1'b0);
    push_comp(3'b010, 3'b000, 3, 8'h41);
    req = 3'b010;
    wait_issue("stable_latency");
    req = 3'b000;
    complete(3, 1'b0, 1'b1, 8'h41);
    cmd_in = {8'h52, 8'h41, 8'h30};

    // Reset in WAIT_DONE aborts silently, then a fresh request works.
    push_issue(3'b010, 8'h41, 1'b1, 1'b0, 1'b0);
    req = 3'b010;
    wait_issue("abort_latency");
    req = 3'b000;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    chk("abort_outputs", 32'({grant, done, timeout_err, sendCommand, command, command_rs, mode4bit, read_busy}), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    commandDone = 1'b1;
    @(posedge CLK); #1;
    commandDone = 1'b0;
    @(posedge CLK); #1;
    push_issue(3'b010, 8'h41, 1'b1, 1'b0, 1'b0);
    push_comp(3'b010, 3'b000, 2, 8'h41);
    req = 3'b010;
    wait_issue("post_reset_latency");
    req = 3'b000;
    complete(2, 1'b0, 1'b0, 8'h41);

    repeat (4) @(posedge CLK);
    #1;
    chk("issue_queue_empty", 32'(iq.size()), 32'd0);
    chk("comp_queue_empty", 32'(cq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit expired");
  end

endmodule
